// File: rtl/serial_adder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// fulladder
//   One-bit full adder cell used by the bit-serial sequencer below.
//   Ports:
//     a, b   - operand bits
//     cin    - carry in
//     sum    - a ^ b ^ cin
//     carry  - carry out
// -----------------------------------------------------------------------------
module fulladder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic carry
);

   assign sum   = a ^ b ^ cin;
   assign carry = (a & b) | (cin & (a ^ b));

endmodule

// -----------------------------------------------------------------------------
// serial_adder
//   Bit-serial WIDTH-bit adder. Operands are captured on an accepted start,
//   then one bit pair per clock (LSB first) is fed through a single fulladder.
//   The carry is registered between cycles and the sum is assembled in a
//   shift register. The public sum/carry are updated only on the edge that
//   enters DONE, so partial sums are never visible.
//
//   Handshake: start is looked at only while idle (busy=0). An accepted start
//   leads to exactly WIDTH SHIFT cycles followed by one DONE cycle in which
//   done=1 and sum/carry hold the new result. start while busy=1 is dropped.
//
//   Ports:
//     clk    - system clock, rising edge
//     rst    - synchronous active-high reset
//     start  - begin an addition (sampled in IDLE only)
//     a, b   - WIDTH-bit operands, captured on the accepted start edge
//     cin    - carry in, captured on the accepted start edge
//     busy   - high in SHIFT and DONE
//     done   - one-cycle pulse, sum/carry valid
//     sum    - registered WIDTH-bit result
//     carry  - registered carry out
// -----------------------------------------------------------------------------
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry
);

   // Counter holds 0..WIDTH-1, so $clog2(WIDTH) bits suffice and it never wraps
   // mid-operation.
   localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;

   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] sum_sr;
   logic [WIDTH-1:0] sum_shift;
   logic             c_reg;
   logic [CW-1:0]    cnt;
   logic             last_bit;

   logic             fa_sum;
   logic             fa_carry;

   fulladder u_fa (
      .a     (a_sr[0]),
      .b     (b_sr[0]),
      .cin   (c_reg),
      .sum   (fa_sum),
      .carry (fa_carry)
   );

   assign last_bit = (cnt == LAST);

   // Next value of the sum shift register: shift right, new bit enters at MSB.
   // After WIDTH shifts the LSB of the result has reached bit 0.
   always_comb begin
      sum_shift            = sum_sr >> 1;
      sum_shift[WIDTH-1]   = fa_sum;
   end

   // ---------------------------------------------------------------------------
   // FSM state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM next state and status outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            busy = 1'b1;
            if (last_bit) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            busy      = 1'b1;
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Datapath
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         a_sr   <= '0;
         b_sr   <= '0;
         sum_sr <= '0;
         c_reg  <= 1'b0;
         cnt    <= '0;
         sum    <= '0;
         carry  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_sr  <= a;
                  b_sr  <= b;
                  c_reg <= cin;
                  cnt   <= '0;
               end
            end
            SHIFT: begin
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               sum_sr <= sum_shift;
               c_reg  <= fa_carry;
               cnt    <= cnt + CW'(1);
               // The final bit's sum/carry go straight to the public outputs
               // on the same edge that enters DONE.
               if (last_bit) begin
                  sum   <= sum_shift;
                  carry <= fa_carry;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
